// File: rtl/pack_pkg.sv
// Shared types and helpers for the narrow-to-wide packer.
package pack_pkg;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_e;

  localparam int MAX_LANES = 64;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio);
  endfunction

  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Lanes 0..cnt set; a negative cnt yields an empty mask.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int cnt, input int ratio);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++)
      m[i] = (i <= cnt) && (i < ratio);
    return m;
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle counter for partial-word flush: counts idle cycles, saturates at TIMEOUT.
module pack_idle_timer
  import pack_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_L,
  input  logic run,
  input  logic clear,
  input  logic ready,
  output logic fire
);

  localparam int TW = tmr_width(TIMEOUT);

  logic [TW-1:0] t;

  always_ff @(posedge clock) begin
    if (!reset_L)                          t <= '0;
    else if (clear)                        t <= '0;
    else if (run && t != TW'(TIMEOUT))     t <= t + 1'b1;
  end

  // Fires on the idle cycle that brings the count to TIMEOUT, or later once unblocked.
  assign fire = run & ready & (t >= TW'(TIMEOUT - 1));

endmodule

// File: rtl/narrow_to_wide_packer.sv
// Packs RATIO beats of IN_W bits into one word, lane 0 first, with keep mask.
// Optional idle-timeout flush of partial words under `PACK_TIMEOUT_EN.
module narrow_to_wide_packer
  import pack_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [IN_W*RATIO-1:0] out_data,
  output logic [RATIO-1:0]      out_keep,
  output logic                  out_last,
  output logic                  out_flush,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = cnt_width(RATIO);

  fill_state_e                  state;
  logic [CNT_W-1:0]             cnt;
  logic [RATIO-1:0][IN_W-1:0]   acc, acc_nxt;
  logic [MAX_LANES-1:0]         mask_c, mask_f;
  logic                         accept, complete, fire;

  assign in_ready = reset_L & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign complete = accept & ((cnt == CNT_W'(RATIO - 1)) | in_last);
  assign mask_c   = lane_mask(int'(cnt), RATIO);
  assign mask_f   = lane_mask(int'(cnt) - 1, RATIO);

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic [IN_W-1:0] base;
    assign base       = (state == IDLE) ? '0 : acc[k];
    assign acc_nxt[k] = (accept && cnt == CNT_W'(k)) ? in_data : base;
  end

`ifdef PACK_TIMEOUT_EN
  pack_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset_L (reset_L),
    .run     ((state != IDLE) & ~accept),
    .clear   ((state == IDLE) | accept),
    .ready   (in_ready),
    .fire    (fire)
  );

  always_ff @(posedge clock) begin
    if (!reset_L)              out_flush <= 1'b0;
    else if (complete | fire)  out_flush <= fire;
  end
`else
  assign fire      = 1'b0;
  assign out_flush = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete | fire) begin
      // fire never coincides with an accept, so acc_nxt is the partial word itself
      out_data  <= acc_nxt;
      out_keep  <= complete ? mask_c[RATIO-1:0] : mask_f[RATIO-1:0];
      out_last  <= complete & in_last;
      out_valid <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
      state     <= IDLE;
    end else begin
      if (accept) begin
        acc   <= acc_nxt;
        cnt   <= cnt + 1'b1;
        state <= FILL;
      end
      if (out_valid & out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_narrow_to_wide_packer.sv
// Self-checking bench for narrow_to_wide_packer (IN_W=8, RATIO=4, TIMEOUT=5).
module tb_narrow_to_wide_packer;

  logic        clock = 1'b0;
  logic        reset_L;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last, out_flush, out_valid, out_ready;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        f;
  } word_t;

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        w;
    logic [31:0] xd;
    logic [3:0]  xk;
    logic        xl;
  } vec_t;

  word_t sb[$];
  vec_t  tbl[15];

  narrow_to_wide_packer #(.IN_W(8), .RATIO(4), .TIMEOUT(5)) dut (
    .clock(clock), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_flush(out_flush), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Scoreboard: every consumed word must match the oldest expected word.
  always @(negedge clock) begin
    if (reset_L && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word got data=%h keep=%b last=%b flush=%b, required none",
                 out_data, out_keep, out_last, out_flush);
      end else begin
        word_t e;
        e = sb.pop_front();
        if ({out_data, out_keep, out_last, out_flush} !== {e.d, e.k, e.l, e.f}) begin
          fails++;
          $display("FAIL word got data=%h keep=%b last=%b flush=%b, required data=%h keep=%b last=%b flush=%b",
                   out_data, out_keep, out_last, out_flush, e.d, e.k, e.l, e.f);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l, input logic f);
    word_t w;
    w.d = d; w.k = k; w.l = l; w.f = f;
    sb.push_back(w);
  endtask

  // Called just after a rising edge or at a falling edge; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_timeout got in_ready=0, required 1 within 50 cycles");
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic reset_pulse();
    reset_L = 1'b0;
    @(negedge clock);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(negedge clock);
    check("outputs_after_reset", 64'({out_data, out_keep, out_last, out_flush, out_valid}), 64'd0);
  endtask

  initial begin
    int seen;
    tbl[0]  = '{8'h11, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[1]  = '{8'h22, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[2]  = '{8'h33, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[3]  = '{8'h44, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0};
    tbl[4]  = '{8'hAA, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[5]  = '{8'hBB, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
    tbl[6]  = '{8'hCC, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[7]  = '{8'hDD, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[8]  = '{8'hEE, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 1'b1, 32'hFFEEDDCC, 4'hF, 1'b0};
    tbl[10] = '{8'h01, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[11] = '{8'h02, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[12] = '{8'h03, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    tbl[13] = '{8'h04, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b1};
    tbl[14] = '{8'h07, 1'b1, 1'b1, 32'h00000007, 4'h1, 1'b1};

    reset_L = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    reset_pulse();

    // Back-to-back table; out_valid must pulse exactly on the cycle after each completion.
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].w) push_exp(tbl[i].xd, tbl[i].xk, tbl[i].xl, 1'b0);
      send_beat(tbl[i].d, tbl[i].l);
      @(negedge clock);
      check($sformatf("out_valid_beat%0d", i), 64'(out_valid), 64'(tbl[i].w));
    end

    // Backpressure: held word stays stable, input stalls, then both words drain in order.
    @(posedge clock); #1;
    out_ready = 1'b0;
    send_beat(8'hA1, 1'b0); send_beat(8'hA2, 1'b0); send_beat(8'hA3, 1'b0); send_beat(8'hA4, 1'b0);
    in_data = 8'hB1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_data", 64'(out_data), 64'h00000000A4A3A2A1);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    push_exp(32'hA4A3A2A1, 4'hF, 1'b0, 1'b0);
    push_exp(32'hB4B3B2B1, 4'hF, 1'b0, 1'b0);
    out_ready = 1'b1;
    send_beat(8'hB1, 1'b0); send_beat(8'hB2, 1'b0); send_beat(8'hB3, 1'b0); send_beat(8'hB4, 1'b0);
    repeat (2) @(negedge clock);

    // Reset with a held word, then reset mid-fill: partial word discarded.
    @(posedge clock); #1;
    out_ready = 1'b0;
    send_beat(8'h77, 1'b1);
    reset_pulse();
    out_ready = 1'b1;
    @(posedge clock); #1;
    send_beat(8'h01, 1'b0); send_beat(8'h02, 1'b0);
    reset_pulse();
    push_exp(32'h40302010, 4'hF, 1'b0, 1'b0);
    send_beat(8'h10, 1'b0); send_beat(8'h20, 1'b0); send_beat(8'h30, 1'b0); send_beat(8'h40, 1'b0);
    repeat (2) @(negedge clock);
    @(posedge clock); #1;

`ifdef PACK_TIMEOUT_EN
    // Single beat then idle: flush visible after exactly 5 idle cycles.
    push_exp(32'h0000005A, 4'h1, 1'b0, 1'b1);
    send_beat(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("timeout_early", 64'(out_valid), 64'd0);
    end
    @(negedge clock);
    check("timeout_fire", 64'(out_valid), 64'd1);
    @(posedge clock); #1;

    // Beat landing on the would-fire cycle wins; timer restarts from the second beat.
    push_exp(32'h00006261, 4'h3, 1'b0, 1'b1);
    send_beat(8'h61, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    send_beat(8'h62, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("timeout_deferred", 64'(out_valid), 64'd0);
    end
    @(negedge clock);
    check("timeout_refire", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
`else
    // No timer: a partial word waits indefinitely.
    send_beat(8'h5A, 1'b0);
    seen = 0;
    repeat (100) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("no_timeout_words", 64'(seen), 64'd0);
    push_exp(32'h0000005A, 4'h3, 1'b1, 1'b0);
    @(posedge clock); #1;
    send_beat(8'h00, 1'b1);
`endif

    repeat (4) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/narrow_to_wide_packer.md
# narrow_to_wide_packer

Parametrised narrow-to-wide deserialiser: packs RATIO beats of IN_W bits into one IN_W*RATIO-bit word, first beat in the least-significant lane. It sits on the receive path ahead of the transaction layer, replacing the fixed 8b-to-32b converter. Compared with that converter it adds:
- valid/ready backpressure on both sides
- packet-end flush of partial words with a lane keep mask
- an optional idle-timeout flush

## Interface
Parameters:
- IN_W, 8: input beat width in bits; ≥1.
- RATIO, 4: beats per output word; ≥2. OUT_W = IN_W*RATIO.
- TIMEOUT, 16: idle cycles before a partial word is flushed; ≥1. Used only with PACK_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset_L  in  1  reset, synchronous, active-low.
- in_data  in  IN_W  input beat.
- in_valid  in  1  beat present.
- in_last  in  1  beat is the final beat of a packet; qualified by in_valid.
- in_ready  out  1  block accepts a beat this cycle.
- out_data  out  OUT_W  packed word; lane k = bits [k*IN_W +: IN_W].
- out_keep  out  RATIO  per-lane valid mask.
- out_last  out  1  word ends a packet.
- out_flush  out  1  word was emitted by timeout.
- out_valid  out  1  word present.
- out_ready  in  1  downstream accepts the word.

## Operation
- A beat is accepted when in_valid & in_ready. The accepted beat is written to lane cnt of the accumulator, and cnt is incremented.
- Fill FSM:
  - IDLE (cnt==0) → FILL on accept without completion.
  - FILL → IDLE on completion.
  - Completion occurs when the accepted beat lands in lane RATIO-1 or carries in_last.
- On completion, the output register loads:
  - out_data = accumulator including the current beat; unfilled lanes are 0.
  - out_keep = lanes 0..cnt set.
  - out_last = in_last.
  - out_flush = 0.
  - out_valid = 1.
  - Then cnt is set to 0 and the accumulator is cleared.
- Output register has depth 1.
  - A word is consumed on out_valid & out_ready.
  - out_valid clears on consumption unless a new word loads in the same cycle.
- in_ready = reset_L & (~out_valid | out_ready). The input stalls whenever the output register is occupied and not draining, regardless of cnt.
- Simultaneous consume and load: the new word replaces the old one with no bubble.
- out_data, out_keep, out_last and out_flush stay stable while out_valid & ~out_ready.
- in_last on the beat landing in lane RATIO-1: out_keep is all ones and out_last=1.
- Reset: synchronous, evaluated on the clock edge while reset_L=0. It clears cnt, the accumulator, the timer, the FSM (to IDLE) and all output registers.
  - Reset values: out_data=0, out_keep=0, out_last=0, out_flush=0, out_valid=0.
  - in_ready=0 while reset_L=0.
  - After reset mid-fill, the partial word is discarded and the next beat goes to lane 0.

## Timing
- Latency: a word is visible one cycle after its completing beat is accepted.
- Throughput: one beat per cycle sustained while out_ready=1. One word per RATIO beats, no idle cycles.
- in_ready is combinational from out_valid (registered), out_ready and reset_L. There is no path from in_valid to in_ready.
- First beat can be accepted on the first cycle with reset_L=1.

## Configuration
- PACK_TIMEOUT_EN defined:
  - The idle timer counts cycles with cnt≠0 and no beat accepted; it resets to 0 on any accept or when cnt==0.
  - When the timer reaches TIMEOUT and in_ready=1, the partial word is emitted as on completion, except out_last=0 and out_flush=1. cnt and the timer then clear.
  - If the timer reaches TIMEOUT while in_ready=0, it saturates and the flush happens on the first cycle in_ready=1.
  - A beat accepted in the same cycle the timer would fire takes priority; the timer clears.
- PACK_TIMEOUT_EN undefined:
  - No timer logic is built; out_flush is tied to 0.
  - A partial word waits indefinitely for more beats or in_last.

## Structure
- Package pack_pkg holds:
  - fill-state enum (IDLE, FILL)
  - function lane_mask(cnt, RATIO) returning the keep mask
  - cnt width constant $clog2(RATIO)
  - timer width constant $clog2(TIMEOUT+1)
- One sub-module, pack_idle_timer (counter, clear, saturate, fire), instantiated only under PACK_TIMEOUT_EN.

## Test plan
All scenarios use IN_W=8, RATIO=4.
- Beats 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 -> one cycle after 0x44: out_data=0x44332211, out_keep=4'b1111, out_last=0, out_valid for 1 cycle.
- 0xAA then 0xBB with in_last -> out_data=0x0000BBAA, out_keep=4'b0011, out_last=1. The following beat 0xCC lands in lane 0.
- Word held with out_ready=0, then 4 further beats offered -> in_ready=0 and out_data stable throughout. After out_ready=1, the first word is consumed, the beats are accepted, and the second word appears with no loss or duplication.
- 0x01,0x02 accepted, then reset_L=0 for 1 cycle -> all outputs 0, in_ready=0 during reset. The next beats 0x10..0x40 give 0x40302010.
- PACK_TIMEOUT_EN, TIMEOUT=5: beat 0x5A then idle -> exactly 5 idle cycles later out_data=0x0000005A, out_keep=4'b0001, out_flush=1, out_last=0. Without the macro, no word appears within 100 cycles.
- PACK_TIMEOUT_EN: beat accepted on the cycle the timer would fire -> no flush, cnt=2, timer restarts.
